// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore control FSM for a shared-memory multi-cycle MIPS datapath.
// One memory port and one ALU are reused across steps. Memory accesses wait on a
// ready handshake and abort back to fetch after MEM_TIMEOUT stalled cycles.
//
// Ports
//   clk_i          clock, rising edge
//   rst_i          asynchronous reset, active-low
//   instr_op_i     IR opcode field (valid from ID onward)
//   mem_ready_i    memory completes the current read/write this cycle
//   PCWrite_o      unconditional PC load
//   PCWriteCond_o  PC load if branch condition (BranchType_o) holds
//   BranchType_o   00 beq, 01 bgt, 10 bgez, 11 bnez
//   PCSource_o     00 ALU result, 01 ALUOut, 10 jump target
//   IorD_o         memory address select: 0 PC, 1 ALUOut
//   MemRead_o      memory read request
//   MemWrite_o     memory write request
//   IRWrite_o      load IR from memory data
//   RegDst_o       00 rt, 01 rd, 10 r31
//   MemtoReg_o     00 ALUOut, 01 MDR, 11 PC (link)
//   RegWrite_o     register file write
//   ALUSrcA_o      0 PC, 1 rs
//   ALUSrcB_o      00 rt, 01 const 4, 10 sign-ext imm, 11 imm<<2
//   ALU_op_o       110 add, 011 compare/sub, 101 or, 000 R-type (funct)
//   state_o        current state encoding (debug)
//   err_o          one-cycle pulse on memory timeout abort
module multicycle_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 255,
   parameter int unsigned TMO_W       = 8
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [5:0] instr_op_i,
   input  logic       mem_ready_i,
   output logic       PCWrite_o,
   output logic       PCWriteCond_o,
   output logic [1:0] BranchType_o,
   output logic [1:0] PCSource_o,
   output logic       IorD_o,
   output logic       MemRead_o,
   output logic       MemWrite_o,
   output logic       IRWrite_o,
   output logic [1:0] RegDst_o,
   output logic [1:0] MemtoReg_o,
   output logic       RegWrite_o,
   output logic       ALUSrcA_o,
   output logic [1:0] ALUSrcB_o,
   output logic [2:0] ALU_op_o,
   output logic [3:0] state_o,
   output logic       err_o
);

   typedef enum logic [3:0] {
      StRst  = 4'd0,
      StIf   = 4'd1,
      StId   = 4'd2,
      StMadr = 4'd3,
      StMrd  = 4'd4,
      StWbm  = 4'd5,
      StMwr  = 4'd6,
      StExr  = 4'd7,
      StWbr  = 4'd8,
      StExi  = 4'd9,
      StWbi  = 4'd10,
      StBr   = 4'd11,
      StJ    = 4'd12,
      StJal  = 4'd13
   } state_e;

   localparam logic [5:0] OpLw   = 6'b100011;
   localparam logic [5:0] OpSw   = 6'b101011;
   localparam logic [5:0] OpBeq  = 6'b000100;
   localparam logic [5:0] OpBgt  = 6'b000111;
   localparam logic [5:0] OpBnez = 6'b000101;
   localparam logic [5:0] OpBgez = 6'b000001;
   localparam logic [5:0] OpJ    = 6'b000010;
   localparam logic [5:0] OpJal  = 6'b000011;
   localparam logic [5:0] OpAddi = 6'b001000;
   localparam logic [5:0] OpLui  = 6'b001111;
   localparam logic [5:0] OpOri  = 6'b001101;

   // Counter value seen on the MEM_TIMEOUT-th consecutive stalled cycle.
   localparam logic [TMO_W-1:0] WaitLast = TMO_W'(MEM_TIMEOUT - 1);

   state_e           state_q, state_d;
   logic [TMO_W-1:0] wait_q, wait_d;
   logic [5:0]       op_q, op_d;
   logic             mem_state;
   logic             timeout;

   assign mem_state = (state_q == StIf) || (state_q == StMrd) || (state_q == StMwr);
   assign timeout   = mem_state && !mem_ready_i && (wait_q == WaitLast);

   // Counter only runs across consecutive stalled cycles of the same access.
   assign wait_d = (mem_state && !mem_ready_i && !timeout) ? wait_q + TMO_W'(1) : '0;

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      case (state_q)
         StRst: state_d = StIf;
         StIf: begin
            if (mem_ready_i) state_d = StId;
         end
         StId: begin
            op_d = instr_op_i;
            case (instr_op_i)
               OpLw, OpSw:                    state_d = StMadr;
               OpBeq, OpBgt, OpBnez, OpBgez:  state_d = StBr;
               OpJ:                           state_d = StJ;
               OpJal:                         state_d = StJal;
               OpAddi, OpLui, OpOri:          state_d = StExi;
               default:                       state_d = StExr;
            endcase
         end
         StMadr: state_d = (op_q == OpLw) ? StMrd : StMwr;
         StMrd: begin
            if (timeout)          state_d = StIf;
            else if (mem_ready_i) state_d = StWbm;
         end
         StMwr: begin
            if (timeout || mem_ready_i) state_d = StIf;
         end
         StExr:   state_d = StWbr;
         StExi:   state_d = StWbi;
         StWbm, StWbr, StWbi, StBr, StJ, StJal: state_d = StIf;
         default: state_d = StRst;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= StRst;
         wait_q  <= '0;
         op_q    <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         op_q    <= op_d;
      end
   end

   // Output decode: a function of state only, except the fetch-completion strobes
   // in IF, which must coincide with the memory returning data.
   always_comb begin
      PCWrite_o     = 1'b0;
      PCWriteCond_o = 1'b0;
      BranchType_o  = 2'b00;
      PCSource_o    = 2'b00;
      IorD_o        = 1'b0;
      MemRead_o     = 1'b0;
      MemWrite_o    = 1'b0;
      IRWrite_o     = 1'b0;
      RegDst_o      = 2'b00;
      MemtoReg_o    = 2'b00;
      RegWrite_o    = 1'b0;
      ALUSrcA_o     = 1'b0;
      ALUSrcB_o     = 2'b00;
      ALU_op_o      = 3'b000;
      case (state_q)
         StIf: begin
            MemRead_o = 1'b1;
            ALUSrcB_o = 2'b01;
            ALU_op_o  = 3'b110;
            if (mem_ready_i) begin
               IRWrite_o = 1'b1;
               PCWrite_o = 1'b1;
            end
         end
         StId: begin
            ALUSrcB_o = 2'b11;
            ALU_op_o  = 3'b110;
         end
         StMadr: begin
            ALUSrcA_o = 1'b1;
            ALUSrcB_o = 2'b10;
            ALU_op_o  = 3'b110;
         end
         StMrd: begin
            MemRead_o = 1'b1;
            IorD_o    = 1'b1;
         end
         StWbm: begin
            RegWrite_o = 1'b1;
            MemtoReg_o = 2'b01;
         end
         StMwr: begin
            MemWrite_o = 1'b1;
            IorD_o     = 1'b1;
         end
         StExr: begin
            ALUSrcA_o = 1'b1;
         end
         StWbr: begin
            RegWrite_o = 1'b1;
            RegDst_o   = 2'b01;
         end
         StExi: begin
            ALUSrcA_o = 1'b1;
            ALUSrcB_o = 2'b10;
            ALU_op_o  = (op_q == OpOri) ? 3'b101 : 3'b110;
         end
         StWbi: begin
            RegWrite_o = 1'b1;
         end
         StBr: begin
            ALUSrcA_o     = 1'b1;
            ALU_op_o      = 3'b011;
            PCWriteCond_o = 1'b1;
            PCSource_o    = 2'b01;
            case (op_q)
               OpBgt:   BranchType_o = 2'b01;
               OpBgez:  BranchType_o = 2'b10;
               OpBnez:  BranchType_o = 2'b11;
               default: BranchType_o = 2'b00;
            endcase
         end
         StJ: begin
            PCWrite_o  = 1'b1;
            PCSource_o = 2'b10;
         end
         StJal: begin
            PCWrite_o  = 1'b1;
            PCSource_o = 2'b10;
            RegWrite_o = 1'b1;
            RegDst_o   = 2'b10;
            MemtoReg_o = 2'b11;
         end
         default: ;
      endcase
   end

   assign state_o = state_q;
   assign err_o   = timeout;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed stimulus for multicycle_ctrl. The driver pushes the
// expected state and control word for each cycle into a queue; a negedge monitor
// pops and compares against what the DUT presents.
module tb_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       rst_i;
   logic [5:0] instr_op_i;
   logic       mem_ready_i;
   logic       PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o;
   logic       RegWrite_o, ALUSrcA_o, err_o;
   logic [1:0] BranchType_o, PCSource_o, RegDst_o, MemtoReg_o, ALUSrcB_o;
   logic [2:0] ALU_op_o;
   logic [3:0] state_o;

   multicycle_ctrl #(.MEM_TIMEOUT(4), .TMO_W(8)) dut (
      .clk_i         (clk),
      .rst_i         (rst_i),
      .instr_op_i    (instr_op_i),
      .mem_ready_i   (mem_ready_i),
      .PCWrite_o     (PCWrite_o),
      .PCWriteCond_o (PCWriteCond_o),
      .BranchType_o  (BranchType_o),
      .PCSource_o    (PCSource_o),
      .IorD_o        (IorD_o),
      .MemRead_o     (MemRead_o),
      .MemWrite_o    (MemWrite_o),
      .IRWrite_o     (IRWrite_o),
      .RegDst_o      (RegDst_o),
      .MemtoReg_o    (MemtoReg_o),
      .RegWrite_o    (RegWrite_o),
      .ALUSrcA_o     (ALUSrcA_o),
      .ALUSrcB_o     (ALUSrcB_o),
      .ALU_op_o      (ALU_op_o),
      .state_o       (state_o),
      .err_o         (err_o)
   );

   always #5 clk = ~clk;

   // Control word: {PCWrite, PCWriteCond, BranchType, PCSource, IorD, MemRead, MemWrite,
   //                IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALU_op, err}
   logic [21:0] act_ctl;
   assign act_ctl = {PCWrite_o, PCWriteCond_o, BranchType_o, PCSource_o, IorD_o, MemRead_o,
                     MemWrite_o, IRWrite_o, RegDst_o, MemtoReg_o, RegWrite_o, ALUSrcA_o,
                     ALUSrcB_o, ALU_op_o, err_o};

   localparam logic [21:0] C_ZERO = '0;
   localparam logic [21:0] C_IF_W = {1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0,
                                     2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 3'b110, 1'b0};
   localparam logic [21:0] C_IF_R = {1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1,
                                     2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 3'b110, 1'b0};
   localparam logic [21:0] C_IF_E = {1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0,
                                     2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 3'b110, 1'b1};
   localparam logic [21:0] C_ID   = {1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0,
                                     2'b00, 2'b00, 1'b0, 1'b0, 2'b11, 3'b110, 1'b0};
   localparam logic [21:0] C_MADR = {1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0,
                                     2'b00, 2'b00, 1'b0, 1'b1, 2'b10, 3'b110, 1'b0};
   localparam logic [21:0] C_MRD  = {1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0,
                                     2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0};
   localparam logic [21:0] C_WBM  = {1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0,
                                     2'b00, 2'b01, 1'b1, 1'b0, 2'b00, 3'b000, 1'b0};
   localparam logic [21:0] C_MWR  = {1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0,
                                     2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0};
   localparam logic [21:0] C_MWR_E = {1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0,
                                      2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 3'b000, 1'b1};
   localparam logic [21:0] C_EXR  = {1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0,
                                     2'b00, 2'b00, 1'b0, 1'b1, 2'b00, 3'b000, 1'b0};
   localparam logic [21:0] C_WBR  = {1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0,
                                     2'b01, 2'b00, 1'b1, 1'b0, 2'b00, 3'b000, 1'b0};
   localparam logic [21:0] C_EXI_OR = {1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0,
                                       2'b00, 2'b00, 1'b0, 1'b1, 2'b10, 3'b101, 1'b0};
   localparam logic [21:0] C_EXI_AD = {1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0,
                                       2'b00, 2'b00, 1'b0, 1'b1, 2'b10, 3'b110, 1'b0};
   localparam logic [21:0] C_WBI  = {1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0,
                                     2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 3'b000, 1'b0};
   localparam logic [21:0] C_BGT  = {1'b0, 1'b1, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0,
                                     2'b00, 2'b00, 1'b0, 1'b1, 2'b00, 3'b011, 1'b0};
   localparam logic [21:0] C_BNEZ = {1'b0, 1'b1, 2'b11, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0,
                                     2'b00, 2'b00, 1'b0, 1'b1, 2'b00, 3'b011, 1'b0};
   localparam logic [21:0] C_J    = {1'b1, 1'b0, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0,
                                     2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0};
   localparam logic [21:0] C_JAL  = {1'b1, 1'b0, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0,
                                     2'b10, 2'b11, 1'b1, 1'b0, 2'b00, 3'b000, 1'b0};

   typedef struct packed {
      logic [3:0]  st;
      logic [21:0] ctl;
   } exp_t;

   exp_t  exp_q[$];
   string nm_q[$];
   int    tests_run = 0;
   int    tests_failed = 0;

   // Advance one clock; drive this cycle's inputs and queue what the DUT must show.
   task automatic cyc(input logic rst, input logic rdy, input logic [5:0] op,
                      input logic [3:0] st, input logic [21:0] ctl, input string nm);
      exp_t e;
      @(posedge clk);
      #1;
      rst_i       = rst;
      mem_ready_i = rdy;
      instr_op_i  = op;
      e.st  = st;
      e.ctl = ctl;
      exp_q.push_back(e);
      nm_q.push_back(nm);
   endtask

   exp_t  mon_e;
   string mon_n;
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         mon_n = nm_q.pop_front();
         tests_run++;
         if (state_o !== mon_e.st || act_ctl !== mon_e.ctl) begin
            tests_failed++;
            $display("FAIL %s: got state=%0d ctl=%b, expected state=%0d ctl=%b",
                     mon_n, state_o, act_ctl, mon_e.st, mon_e.ctl);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011, BGT = 6'b000111;
   localparam logic [5:0] BNEZ = 6'b000101, J = 6'b000010, JAL = 6'b000011;
   localparam logic [5:0] ORI = 6'b001101, ADDI = 6'b001000;

   initial begin
      rst_i       = 1'b0;
      mem_ready_i = 1'b1;
      instr_op_i  = R;
      // Reset held, then released mid-cycle: RST persists until the next edge.
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, R, 4'd0, C_ZERO, "reset_hold");
      cyc(1'b1, 1'b1, R, 4'd0, C_ZERO, "reset_release");
      // R-type
      cyc(1'b1, 1'b1, R, 4'd1, C_IF_R, "r_if");
      cyc(1'b1, 1'b1, R, 4'd2, C_ID,   "r_id");
      cyc(1'b1, 1'b1, R, 4'd7, C_EXR,  "r_exr");
      cyc(1'b1, 1'b1, R, 4'd8, C_WBR,  "r_wbr");
      // lw with three stalled cycles in MRD
      cyc(1'b1, 1'b1, LW, 4'd1, C_IF_R, "lw_if");
      cyc(1'b1, 1'b1, LW, 4'd2, C_ID,   "lw_id");
      cyc(1'b1, 1'b1, LW, 4'd3, C_MADR, "lw_madr");
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, LW, 4'd4, C_MRD, "lw_mrd_wait");
      cyc(1'b1, 1'b1, LW, 4'd4, C_MRD, "lw_mrd_ready");
      cyc(1'b1, 1'b1, LW, 4'd5, C_WBM, "lw_wbm");
      // bgt
      cyc(1'b1, 1'b1, BGT, 4'd1,  C_IF_R, "bgt_if");
      cyc(1'b1, 1'b1, BGT, 4'd2,  C_ID,   "bgt_id");
      cyc(1'b1, 1'b1, BGT, 4'd11, C_BGT,  "bgt_br");
      // bnez
      cyc(1'b1, 1'b1, BNEZ, 4'd1,  C_IF_R, "bnez_if");
      cyc(1'b1, 1'b1, BNEZ, 4'd2,  C_ID,   "bnez_id");
      cyc(1'b1, 1'b1, BNEZ, 4'd11, C_BNEZ, "bnez_br");
      // j, jal
      cyc(1'b1, 1'b1, J,   4'd1,  C_IF_R, "j_if");
      cyc(1'b1, 1'b1, J,   4'd2,  C_ID,   "j_id");
      cyc(1'b1, 1'b1, J,   4'd12, C_J,    "j_j");
      cyc(1'b1, 1'b1, JAL, 4'd1,  C_IF_R, "jal_if");
      cyc(1'b1, 1'b1, JAL, 4'd2,  C_ID,   "jal_id");
      cyc(1'b1, 1'b1, JAL, 4'd13, C_JAL,  "jal_jal");
      // sw with memory stuck: abort on the 4th stalled cycle
      cyc(1'b1, 1'b1, SW, 4'd1, C_IF_R, "sw_if");
      cyc(1'b1, 1'b1, SW, 4'd2, C_ID,   "sw_id");
      cyc(1'b1, 1'b1, SW, 4'd3, C_MADR, "sw_madr");
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, SW, 4'd6, C_MWR, "sw_mwr_wait");
      cyc(1'b1, 1'b0, SW, 4'd6, C_MWR_E, "sw_mwr_timeout");
      cyc(1'b1, 1'b0, SW, 4'd1, C_IF_W,  "sw_refetch_wait");
      // ori then addi: the counter restarted, so one stall in IF is harmless
      cyc(1'b1, 1'b1, ORI, 4'd1,  C_IF_R,   "ori_if");
      cyc(1'b1, 1'b1, ORI, 4'd2,  C_ID,     "ori_id");
      cyc(1'b1, 1'b1, ORI, 4'd9,  C_EXI_OR, "ori_exi");
      cyc(1'b1, 1'b1, ORI, 4'd10, C_WBI,    "ori_wbi");
      cyc(1'b1, 1'b1, ADDI, 4'd1, C_IF_R,   "addi_if");
      cyc(1'b1, 1'b1, ADDI, 4'd2, C_ID,     "addi_id");
      cyc(1'b1, 1'b1, ADDI, 4'd9, C_EXI_AD, "addi_exi");
      cyc(1'b1, 1'b1, ADDI, 4'd10, C_WBI,   "addi_wbi");
      // Fetch timeout: stays in IF, err on 4th stalled cycle, then fetch resumes
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, R, 4'd1, C_IF_W, "if_wait");
      cyc(1'b1, 1'b0, R, 4'd1, C_IF_E, "if_timeout");
      cyc(1'b1, 1'b0, R, 4'd1, C_IF_W, "if_after_timeout");
      cyc(1'b1, 1'b1, R, 4'd1, C_IF_R, "if_resume");
      // Reset mid-instruction (in ID) takes effect immediately
      cyc(1'b0, 1'b1, R, 4'd0, C_ZERO, "midreset");
      cyc(1'b1, 1'b1, R, 4'd0, C_ZERO, "midreset_release");
      cyc(1'b1, 1'b1, R, 4'd1, C_IF_R, "midreset_if");
      @(posedge clk);
      @(negedge clk);
      #1;
      tests_run++;
      if (exp_q.size() != 0) begin
         tests_failed++;
         $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
